// File: rtl/flexible_clock.sv
// flexible_clock
//
// Divides clk_in down to a 50 % duty-cycle square wave. clk_out toggles once
// every div cycles of clk_in, where div starts at CLK_DIV and can be reloaded
// at run time through div_load/div_value. The output period is therefore
// 2*div enabled input cycles.
//
// Parameters:
//   CLK_DIV   toggle interval in clk_in cycles, 1 .. 2**WIDTH-1 (default 50_000)
//   WIDTH     width of the internal counter and of div_value (default 32)
//
// Ports:
//   clk_in     in   1      sole clock, everything is posedge clk_in
//   rst        in   1      synchronous active-high reset
//   en         in   1      count enable (tie high when unused, see template)
//   div_load   in   1      load div_value as the new divisor (0 is taken as 1)
//   div_value  in   WIDTH  runtime divisor
//   clk_out    out  1      divided clock, registered
//   tick       out  1      one-cycle pulse with every clk_out toggle
//   rise       out  1      one-cycle pulse when clk_out goes 0->1
//   fall       out  1      one-cycle pulse when clk_out goes 1->0
//
// Priority each cycle: rst, then div_load, then en. A load abandons the
// current half-period; the next toggle comes div_value enabled cycles later.
// A load is honoured even while en is low.
//
// Instantiation template (en tied high when no gating is wanted):
//
//   flexible_clock #(
//     .CLK_DIV (50_000),
//     .WIDTH   (32)
//   ) u_div_1khz (
//     .clk_in    (clk),
//     .rst       (rst),
//     .en        (1'b1),
//     .div_load  (1'b0),
//     .div_value ('0),
//     .clk_out   (clk_1kHz),
//     .tick      (),
//     .rise      (),
//     .fall      ()
//   );

module flexible_clock #(
  parameter longint unsigned CLK_DIV = 50_000,
  parameter int unsigned     WIDTH   = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             clk_out,
  output logic             tick,
  output logic             rise,
  output logic             fall
);

  // Largest divisor the counter can represent. For WIDTH=64 the shift
  // yields zero and the subtraction wraps to all ones, which is correct.
  localparam longint unsigned MAX_DIV = (64'd1 << WIDTH) - 64'd1;

  generate
    if ((WIDTH == 0) || (WIDTH > 64) || (CLK_DIV == 0) || (CLK_DIV > MAX_DIV)) begin : g_bad_param
      $error("flexible_clock: CLK_DIV must lie in 1 .. 2**WIDTH-1 and WIDTH in 1 .. 64");
    end
  endgenerate

  localparam logic [WIDTH-1:0] DIV_INIT = CLK_DIV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // ---------------------------------------------------------------------
  // State
  //
  // The divisor is stored as an offset from CLK_DIV (div_ofs_reg = div ^
  // CLK_DIV). Every register in this block therefore holds all zeros in its
  // reset state, so the FPGA's zero power-up value is already the reset
  // state and the divider runs correctly without rst ever being asserted.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] div_ofs_reg;
  logic [WIDTH-1:0] div_ofs_next;
  logic             clk_out_reg;
  logic             clk_out_next;
  logic             tick_reg;
  logic             tick_next;
  logic             rise_reg;
  logic             rise_next;
  logic             fall_reg;
  logic             fall_next;

  // Decoded divisor currently in force, and the value a load would install.
  logic [WIDTH-1:0] div_cur;
  logic [WIDTH-1:0] div_new;
  logic             terminal;

  assign div_cur  = div_ofs_reg ^ DIV_INIT;
  assign div_new  = (div_value == '0) ? ONE : div_value;

  // count runs 0 .. div_cur-1, so it can never wrap at 2**WIDTH.
  assign terminal = (count_reg == (div_cur - ONE));

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    count_next   = count_reg;
    div_ofs_next = div_ofs_reg;
    clk_out_next = clk_out_reg;
    tick_next    = 1'b0;
    rise_next    = 1'b0;
    fall_next    = 1'b0;

    if (div_load) begin
      // New divisor restarts the half-period; the output level is kept.
      div_ofs_next = div_new ^ DIV_INIT;
      count_next   = '0;
    end else if (en) begin
      if (terminal) begin
        count_next   = '0;
        clk_out_next = ~clk_out_reg;
        tick_next    = 1'b1;
        // Pulses are registered together with clk_out, so they line up with
        // the cycle in which the new level first appears.
        rise_next    = ~clk_out_reg;
        fall_next    = clk_out_reg;
      end else begin
        count_next   = count_reg + ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      count_reg   <= '0;
      div_ofs_reg <= '0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
    end else begin
      count_reg   <= count_next;
      div_ofs_reg <= div_ofs_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign rise    = rise_reg;
  assign fall    = fall_reg;

endmodule

// File: tb/tb_flexible_clock.sv
// Bench for flexible_clock. Six instances share one clock, each exercising a
// different scenario:
//   0: CLK_DIV=4, free running from power-up
//   1: CLK_DIV=1, fastest divisor
//   2: CLK_DIV=3, enable dropped for 5 cycles mid high phase
//   3: CLK_DIV=10, runtime loads (2, then 0, then 3 with en low)
//   4: CLK_DIV=5, reset mid-period, load, then reset together with load
//   5: CLK_DIV=4095, WIDTH=12, long-period measurement (maximum divisor)
// A reference model tracks half-periods as "enabled cycles elapsed since the
// last toggle or load"; its outputs are compared every cycle.

module tb_flexible_clock;

  localparam int NI = 6;
  localparam int DIVS [NI] = '{4, 1, 3, 10, 5, 4095};

  logic          clk;
  logic [NI-1:0] rst_v;
  logic [NI-1:0] en_v;
  logic [NI-1:0] load_v;
  logic [31:0]   val_v [NI];
  wire  [NI-1:0] co_v;
  wire  [NI-1:0] tk_v;
  wire  [NI-1:0] rs_v;
  wire  [NI-1:0] fl_v;

  int checks;
  int errors;
  int cyc;

  // Model state; every field is zero in the power-up/reset state.
  int dv_m  [NI];   // loaded divisor, 0 means "CLK_DIV of that instance"
  int el_m  [NI];   // enabled cycles since last toggle or load
  bit lvl_m [NI];
  bit tk_m  [NI];
  bit rs_m  [NI];
  bit fl_m  [NI];

  int rise_t [8];
  int fall_t [8];
  int n_rise;
  int n_fall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  flexible_clock #(.CLK_DIV(4)) u_a (
    .clk_in(clk), .rst(rst_v[0]), .en(en_v[0]), .div_load(load_v[0]),
    .div_value(val_v[0]), .clk_out(co_v[0]), .tick(tk_v[0]), .rise(rs_v[0]), .fall(fl_v[0]));

  flexible_clock #(.CLK_DIV(1)) u_b (
    .clk_in(clk), .rst(rst_v[1]), .en(en_v[1]), .div_load(load_v[1]),
    .div_value(val_v[1]), .clk_out(co_v[1]), .tick(tk_v[1]), .rise(rs_v[1]), .fall(fl_v[1]));

  flexible_clock #(.CLK_DIV(3)) u_c (
    .clk_in(clk), .rst(rst_v[2]), .en(en_v[2]), .div_load(load_v[2]),
    .div_value(val_v[2]), .clk_out(co_v[2]), .tick(tk_v[2]), .rise(rs_v[2]), .fall(fl_v[2]));

  flexible_clock #(.CLK_DIV(10)) u_d (
    .clk_in(clk), .rst(rst_v[3]), .en(en_v[3]), .div_load(load_v[3]),
    .div_value(val_v[3]), .clk_out(co_v[3]), .tick(tk_v[3]), .rise(rs_v[3]), .fall(fl_v[3]));

  flexible_clock #(.CLK_DIV(5)) u_e (
    .clk_in(clk), .rst(rst_v[4]), .en(en_v[4]), .div_load(load_v[4]),
    .div_value(val_v[4]), .clk_out(co_v[4]), .tick(tk_v[4]), .rise(rs_v[4]), .fall(fl_v[4]));

  flexible_clock #(.CLK_DIV(4095), .WIDTH(12)) u_f (
    .clk_in(clk), .rst(rst_v[5]), .en(en_v[5]), .div_load(load_v[5]),
    .div_value(val_v[5][11:0]), .clk_out(co_v[5]), .tick(tk_v[5]), .rise(rs_v[5]), .fall(fl_v[5]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int eff_div(input int i, input int dv);
    return (dv == 0) ? DIVS[i] : dv;
  endfunction

  // Reference model: a half-period lasts exactly div enabled cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      tk_m[i] <= 1'b0;
      rs_m[i] <= 1'b0;
      fl_m[i] <= 1'b0;
      if (rst_v[i]) begin
        dv_m[i]  <= 0;
        el_m[i]  <= 0;
        lvl_m[i] <= 1'b0;
      end else if (load_v[i]) begin
        dv_m[i] <= (val_v[i] == 32'd0) ? 1 : int'(val_v[i]);
        el_m[i] <= 0;
      end else if (en_v[i]) begin
        if (el_m[i] + 1 >= eff_div(i, dv_m[i])) begin
          el_m[i]  <= 0;
          lvl_m[i] <= !lvl_m[i];
          tk_m[i]  <= 1'b1;
          rs_m[i]  <= !lvl_m[i];
          fl_m[i]  <= lvl_m[i];
        end else begin
          el_m[i] <= el_m[i] + 1;
        end
      end
    end
  end

  // Compare process: model vs DUT every cycle, plus hand-computed pins.
  // Literal nibbles are {clk_out, tick, rise, fall}; cyc = edges seen so far.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d_outs", i), {28'd0, co_v[i], tk_v[i], rs_v[i], fl_v[i]},
          {28'd0, lvl_m[i], tk_m[i], rs_m[i], fl_m[i]});
    end
    if (rs_v[5]) begin
      if (n_rise < 8) rise_t[n_rise] = cyc;
      n_rise++;
    end
    if (fl_v[5]) begin
      if (n_fall < 8) fall_t[n_fall] = cyc;
      n_fall++;
    end
    case (cyc)
      1:  chk("b_first_rise", {28'd0, co_v[1], tk_v[1], rs_v[1], fl_v[1]}, 32'b1110);
      2:  chk("b_first_fall", {28'd0, co_v[1], tk_v[1], rs_v[1], fl_v[1]}, 32'b0101);
      3: begin
        chk("a_low_c3", {28'd0, co_v[0], tk_v[0], rs_v[0], fl_v[0]}, 32'b0000);
        chk("c_rise_c3", {28'd0, co_v[2], tk_v[2], rs_v[2], fl_v[2]}, 32'b1110);
      end
      4:  chk("a_rise_c4", {28'd0, co_v[0], tk_v[0], rs_v[0], fl_v[0]}, 32'b1110);
      7:  chk("a_high_c7", {28'd0, co_v[0], tk_v[0], rs_v[0], fl_v[0]}, 32'b1000);
      8: begin
        chk("a_fall_c8", {28'd0, co_v[0], tk_v[0], rs_v[0], fl_v[0]}, 32'b0101);
        chk("e_high_c8", {28'd0, co_v[4], tk_v[4], rs_v[4], fl_v[4]}, 32'b1000);
      end
      9:  chk("e_rst_c9", {28'd0, co_v[4], tk_v[4], rs_v[4], fl_v[4]}, 32'b0000);
      10: begin
        chk("c_stall_c10", {28'd0, co_v[2], tk_v[2], rs_v[2], fl_v[2]}, 32'b1000);
        chk("d_rise_c10", {28'd0, co_v[3], tk_v[3], rs_v[3], fl_v[3]}, 32'b1110);
      end
      11: chk("c_fall_c11", {28'd0, co_v[2], tk_v[2], rs_v[2], fl_v[2]}, 32'b0101);
      12: chk("a_rise_c12", {28'd0, co_v[0], tk_v[0], rs_v[0], fl_v[0]}, 32'b1110);
      14: begin
        chk("e_rise_c14", {28'd0, co_v[4], tk_v[4], rs_v[4], fl_v[4]}, 32'b1110);
        chk("d_load_hold", {28'd0, co_v[3], tk_v[3], rs_v[3], fl_v[3]}, 32'b1000);
      end
      15: chk("d_hold_c15", {28'd0, co_v[3], tk_v[3], rs_v[3], fl_v[3]}, 32'b1000);
      16: chk("d_fall_c16", {28'd0, co_v[3], tk_v[3], rs_v[3], fl_v[3]}, 32'b0101);
      31: chk("d_div0_c31", {28'd0, co_v[3], tk_v[3], rs_v[3], fl_v[3]}, 32'b1110);
      32: chk("d_div0_c32", {28'd0, co_v[3], tk_v[3], rs_v[3], fl_v[3]}, 32'b0101);
      34: chk("e_rstld_c34", {28'd0, co_v[4], tk_v[4], rs_v[4], fl_v[4]}, 32'b0000);
      35: chk("e_rstld_c35", {28'd0, co_v[4], tk_v[4], rs_v[4], fl_v[4]}, 32'b1110);
      40: chk("e_fall_c40", {28'd0, co_v[4], tk_v[4], rs_v[4], fl_v[4]}, 32'b0101);
      44: chk("d_enld_c44", {28'd0, co_v[3], tk_v[3], rs_v[3], fl_v[3]}, 32'b1000);
      45: chk("d_enld_c45", {28'd0, co_v[3], tk_v[3], rs_v[3], fl_v[3]}, 32'b0101);
      default: ;
    endcase
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    rst_v  = '0;
    en_v   = '1;
    load_v = '0;
    for (int i = 0; i < NI; i++) val_v[i] = 32'd0;

    #1;
    chk("powerup_outs", {8'd0, co_v, tk_v, rs_v, fl_v}, 32'd0);

    wait_cyc(4);  en_v[2] = 1'b0;                     // stall u_c for edges 5..9
    wait_cyc(8);  rst_v[4] = 1'b1;                    // u_e: clk_out=1, count=3
    wait_cyc(9);  en_v[2] = 1'b1; rst_v[4] = 1'b0;
    wait_cyc(13); load_v[3] = 1'b1; val_v[3] = 32'd2; // 4 cycles after rise at 10
    wait_cyc(14); load_v[3] = 1'b0;
    wait_cyc(19); load_v[4] = 1'b1; val_v[4] = 32'd2;
    wait_cyc(20); load_v[4] = 1'b0;
    wait_cyc(29);
    load_v[3] = 1'b1; val_v[3] = 32'd0;               // zero coerces to 1
    rst_v[4]  = 1'b1; load_v[4] = 1'b1; val_v[4] = 32'd9;
    wait_cyc(30); load_v[3] = 1'b0; rst_v[4] = 1'b0; load_v[4] = 1'b0;
    wait_cyc(39); en_v[3] = 1'b0; load_v[3] = 1'b1; val_v[3] = 32'd3;
    wait_cyc(40); load_v[3] = 1'b0;
    wait_cyc(42); en_v[3] = 1'b1;

    // Long divisor: rises at 4095, 12285, 20475, 28665; falls at 8190, ...
    wait_cyc(28700);
    chk("f_rise_count", (n_rise >= 4) ? 32'd1 : 32'd0, 32'd1);
    chk("f_fall_count", (n_fall >= 3) ? 32'd1 : 32'd0, 32'd1);
    chk("f_first_rise", rise_t[0], 32'd4095);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("f_period%0d", k), rise_t[k+1] - rise_t[k], 32'd8190);
      chk($sformatf("f_high%0d", k), fall_t[k] - rise_t[k], 32'd4095);
      chk($sformatf("f_low%0d", k), rise_t[k+1] - fall_t[k], 32'd4095);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flexible_clock.md
# flexible_clock

Parameterised clock divider producing a 50 % duty-cycle square wave from the system clock. `clk_out` toggles once every `CLK_DIV` input cycles, so its period is 2·`CLK_DIV` cycles of `clk_in`. With a 100 MHz `clk_in`:

- `CLK_DIV`=50_000 gives 1 kHz.
- `CLK_DIV`=5_000_000 gives 10 Hz.

Several instances sit at the top level. They feed slow timebases (blink rates, scan clocks) as clock or data signals, and the divisor can be reloaded at run time.

## Interface
Parameters:
- `CLK_DIV`, default 50_000: toggle interval in `clk_in` cycles. Legal range is 1 to 2^`WIDTH`−1; an out-of-range value is an elaboration error.
- `WIDTH`, default 32: width of the internal counter and of `div_value`.

Ports:
- `clk_in` (input, 1): sole clock. Everything is `posedge clk_in`.
- `rst` (input, 1): reset. One clock; reset is synchronous and active-high.
- `en` (input, 1): count enable. When unconnected it must read as 1; implement it with a default tie-high at the instantiation template.
- `div_load` (input, 1): when high, load `div_value` as the new divisor.
- `div_value` (input, `WIDTH`): runtime divisor.
- `clk_out` (output, 1): divided clock, registered.
- `tick` (output, 1): one-cycle pulse, coincident with each `clk_out` toggle edge.
- `rise` (output, 1): one-cycle pulse when `clk_out` goes 0→1.
- `fall` (output, 1): one-cycle pulse when `clk_out` goes 1→0.

## Operation
- State is held in three registers:
  - `count[WIDTH-1:0]`
  - `div_reg[WIDTH-1:0]`, initialised to `CLK_DIV`
  - `clk_out`
- Priority each cycle, highest first: `rst`, then `div_load`, then `en`.
- **`rst`=1:**
  - `count`=0, `clk_out`=0, `tick`=`rise`=`fall`=0.
  - `div_reg`=`CLK_DIV`.
- **`div_load`=1** (and not `rst`):
  - `div_reg` = `div_value`, except that `div_value`=0 is coerced to 1.
  - `count`=0.
  - `clk_out` holds its value; no pulses.
- **`en`=1, no load, and `count` == `div_reg`−1:**
  - `count`=0.
  - `clk_out` inverts.
  - `tick`=1.
  - `rise`=1 if the new `clk_out` is 1; otherwise `fall`=1.
- **`en`=1 otherwise:** `count` increments by 1; pulses are 0.
- **`en`=0:** `count` and `clk_out` freeze; pulses are 0.
- `count` never exceeds `div_reg`−1, so no wrap-around at 2^`WIDTH` is possible.
- `div_reg`=1: `clk_out` toggles every enabled cycle, giving `clk_in`/2 while enabled.
- All outputs are registered; there is no combinational path from input to output.
- Power-up initial values equal the reset values (FPGA init), so the block runs without `rst` asserted.

## Timing
- **First toggle:** after `rst` deasserts in cycle 0, `count` advances from cycle 1. The first toggle of `clk_out` is at the end of enabled cycle `CLK_DIV`, i.e. `clk_out` is 1 from cycle `CLK_DIV`+1.
- **Steady state:** high for exactly `div_reg` enabled cycles, low for exactly `div_reg` enabled cycles.
- **Pulses:** `tick`, `rise` and `fall` are asserted in the same cycle in which the new `clk_out` value first appears. Each lasts exactly 1 cycle.
- **Mid-period `div_load`:** the current half-period is abandoned. The next toggle occurs `div_value` enabled cycles after the load cycle.
- **`div_load` with `en`=0:** the load still takes effect.
- **`rst` mid-period:** `clk_out` returns to 0 on the next edge regardless of phase.
- **`rst` and `div_load` together:** reset wins; `div_reg`=`CLK_DIV`.

## Test plan
- **Power-on count:** `CLK_DIV`=4, no `rst`, `en`=1 → `clk_out` pattern 0000 1111 0000… from cycle 0. `tick` asserted on cycles 4, 8, 12. `rise` on cycles 4 and 12; `fall` on cycle 8.
- **Fastest divisor:** `CLK_DIV`=1 → `clk_out` alternates every cycle and `tick` is high every cycle.
- **Enable gating:** `CLK_DIV`=3; drop `en` for 5 cycles mid-high-phase → `clk_out` stays 1 for 3+5 cycles total. No pulses during the stall.
- **Runtime load:** `CLK_DIV`=10, 4 cycles after a toggle pulse `div_load` with `div_value`=2 → `clk_out` holds its value and the next toggle is 2 cycles after the load. Subsequent half-periods are 2 cycles. A later load of `div_value`=0 yields half-periods of 1.
- **Reset mid-operation:** `CLK_DIV`=5, assert `rst` while `clk_out`=1 and `count`=3 → the next cycle has `clk_out`=0, `count`=0 and a restored divisor of 5. Assert `rst` together with `div_load` → `div_reg`=5.
- **Long divisor:** `CLK_DIV`=50_000 → measured `clk_out` period is 100_000 cycles with a 50 % duty cycle, over at least 3 periods.
